// File: rtl/reaction_round_ctrl_if.sv
// Board-side signal bundle for the reaction game round controller.
// master = board/bench side (drives start and switches), slave = controller.
interface reaction_round_ctrl_if #(
  parameter int SCORE_W = 4
);
  // There is no valid/ready handshake on this bundle. start, p1_sw and p2_sw
  // are level inputs sampled on every clk. Every output is either a register
  // or a decode of the state register, so it changes only at a clk edge.
  logic               start;
  logic               p1_sw;
  logic               p2_sw;
  logic               go_lamp;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic [1:0]         false_start;
  logic [15:0]        reaction_ms;
  logic               round_done;
  logic               match_over;
  logic [2:0]         state_o;

  modport master (
    output start, p1_sw, p2_sw,
    input  go_lamp, p1_score, p2_score, winner, false_start,
           reaction_ms, round_done, match_over, state_o
  );

  modport slave (
    input  start, p1_sw, p2_sw,
    output go_lamp, p1_score, p2_score, winner, false_start,
           reaction_ms, round_done, match_over, state_o
  );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Round sequencer and arbiter for the two-player reaction game.
// Produces the ms tick, runs a pseudo-random countdown and lights the go lamp.
// It decides which switch fired first, punishes false starts, keeps the scores
// and ends the match when a player reaches WIN_SCORE.
module reaction_round_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY    = 1000,
  parameter int DELAY_MASK   = 2047,
  parameter int RESP_TIMEOUT = 3000,
  parameter int RESULT_HOLD  = 2000,
  parameter int WIN_SCORE    = 5,
  parameter int SCORE_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reaction_round_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_GO         = 3'd3,
    S_RESULT     = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_t;

  localparam int                 TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [15:0]        MASK       = 16'(DELAY_MASK);
  localparam logic [16:0]        DELAY_BASE = 17'(MIN_DELAY);
  localparam logic [15:0]        TMO_LOAD   = 16'(RESP_TIMEOUT);
  localparam logic [15:0]        HOLD_LOAD  = 16'(RESULT_HOLD);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   lfsr;
  logic          start_q, p1_q, p2_q;
  logic          start_rise, p1_rise, p2_rise;

  state_t             state_q, state_d;
  logic [16:0]        delay_q, delay_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [15:0]        hold_q, hold_d;
  logic [SCORE_W-1:0] p1s_q, p1s_d, p2s_q, p2s_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         fs_q, fs_d;
  logic [15:0]        rms_q, rms_d;
  logic               done_q, done_d;
  logic               restart_q, restart_d;

  assign tick       = (tick_cnt == TICK_LAST);
  assign start_rise = bus.start & ~start_q;
  assign p1_rise    = bus.p1_sw & ~p1_q;
  assign p2_rise    = bus.p2_sw & ~p2_q;

  // Free-running ms tick divider, active in every state.
  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Fibonacci LFSR, taps 16,14,13,11, advances every clk.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Previous-cycle copies of the inputs, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      p1_q    <= bus.p1_sw;
      p2_q    <= bus.p2_sw;
    end
  end

  // State, counters and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      delay_q   <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      p1s_q     <= '0;
      p2s_q     <= '0;
      winner_q  <= '0;
      fs_q      <= '0;
      rms_q     <= '0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      p1s_q     <= p1s_d;
      p2s_q     <= p2s_d;
      winner_q  <= winner_d;
      fs_q      <= fs_d;
      rms_q     <= rms_d;
      done_q    <= done_d;
      restart_q <= restart_d;
    end
  end

  // Next-state and datapath decisions for the round sequencer.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    tmo_d     = tmo_q;
    hold_d    = hold_q;
    p1s_d     = p1s_q;
    p2s_d     = p2s_q;
    winner_d  = winner_q;
    fs_d      = fs_q;
    rms_d     = rms_q;
    done_d    = 1'b0;
    restart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        p1s_d    = '0;
        p2s_d    = '0;
        winner_d = 2'b00;
        fs_d     = 2'b00;
        rms_d    = '0;
        // restart_q carries a start edge taken in MATCH_OVER through IDLE.
        if (start_rise || restart_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (!bus.p1_sw && !bus.p2_sw) begin
          delay_d = DELAY_BASE + {1'b0, lfsr & MASK};
          state_d = S_COUNTDOWN;
        end
      end
      S_COUNTDOWN: begin
        // A false start beats the countdown reaching zero in the same cycle.
        if (p1_rise || p2_rise) begin
          fs_d     = {p2_rise, p1_rise};
          winner_d = 2'b00;
          if (p1_rise && (p1s_q != '0)) p1s_d = p1s_q - 1'b1;
          if (p2_rise && (p2s_q != '0)) p2s_d = p2s_q - 1'b1;
          state_d  = S_RESULT;
          hold_d   = HOLD_LOAD;
          done_d   = 1'b1;
        end else if (delay_q == '0) begin
          rms_d   = '0;
          tmo_d   = TMO_LOAD;
          state_d = S_GO;
        end else if (tick) begin
          delay_d = delay_q - 1'b1;
        end
      end
      S_GO: begin
        if (tick && (rms_q != 16'hFFFF)) rms_d = rms_q + 16'd1;
        // A switch edge beats a timeout falling in the same cycle.
        if (p1_rise || p2_rise) begin
          winner_d = {p2_rise, p1_rise};
          fs_d     = 2'b00;
          if (p1_rise && !p2_rise && (p1s_q < WIN)) p1s_d = p1s_q + 1'b1;
          if (p2_rise && !p1_rise && (p2s_q < WIN)) p2s_d = p2s_q + 1'b1;
          state_d  = S_RESULT;
          hold_d   = HOLD_LOAD;
          done_d   = 1'b1;
        end else if (tick) begin
          if (tmo_q <= 16'd1) begin
            winner_d = 2'b00;
            fs_d     = 2'b00;
            state_d  = S_RESULT;
            hold_d   = HOLD_LOAD;
            done_d   = 1'b1;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
      end
      S_RESULT: begin
        if (tick) begin
          if (hold_q <= 16'd1) begin
            if ((p1s_q == WIN) || (p2s_q == WIN)) state_d = S_MATCH_OVER;
            else                                  state_d = S_ARM;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
      end
      S_MATCH_OVER: begin
        if (start_rise) begin
          p1s_d     = '0;
          p2s_d     = '0;
          winner_d  = 2'b00;
          fs_d      = 2'b00;
          rms_d     = '0;
          restart_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.go_lamp     = (state_q == S_GO);
  assign bus.match_over  = (state_q == S_MATCH_OVER);
  assign bus.state_o     = state_q;
  assign bus.p1_score    = p1s_q;
  assign bus.p2_score    = p2s_q;
  assign bus.winner      = winner_q;
  assign bus.false_start = fs_q;
  assign bus.reaction_ms = rms_q;
  assign bus.round_done  = done_q;
endmodule
